reservoir: RTL and testbench

RESERVOIR -- requirements
Module: reservoir

---
 rtl/reservoir.sv | 86 ++++++++
 tb/tb_reservoir.sv | 128 ++++++++++++
 2 files changed

// File: rtl/reservoir.sv
// Nine-neuron clipped-integer reservoir: each enabled edge rotates the neuron ring by one
// and adds a +/-1 drive taken from a fixed symbol pattern XORed with readout feedback.
module reservoir #(
    parameter int KAPPA = 3
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic [2:0] iWord,
    input  logic [5:0] iY,
    output logic [8:0] oOut
);

    localparam logic signed [3:0] KAP_POS = 4'(KAPPA);
    localparam logic signed [3:0] KAP_NEG = -4'(KAPPA);

    logic signed [2:0] x_r    [0:8];
    logic signed [2:0] next_s [0:8];
    logic [8:0]        mask_s;
    logic [8:0]        drive_s;

    function automatic logic [8:0] pattern(input logic [2:0] word);
        logic [8:0] p;
        case (word)
            3'd0:    p = 9'h1A5;
            3'd1:    p = 9'h0D3;
            3'd2:    p = 9'h16E;
            3'd3:    p = 9'h0B9;
            3'd4:    p = 9'h1C7;
            3'd5:    p = 9'h05C;
            3'd6:    p = 9'h13A;
            3'd7:    p = 9'h1FF;
            default: p = 9'h000;
        endcase
        return p;
    endfunction

    // Saturate the widened sum back into the +/-KAPPA band so values never wrap.
    function automatic logic signed [2:0] clip(input logic signed [3:0] s);
        logic signed [3:0] r;
        if (s > KAP_POS) begin
            r = KAP_POS;
        end else if (s < KAP_NEG) begin
            r = KAP_NEG;
        end else begin
            r = s;
        end
        return r[2:0];
    endfunction

    // Next-state: rotate toward higher index, add +/-1 drive, clip.
    always_comb begin
        mask_s  = {iY[2:0], iY[5:0]};
        drive_s = pattern(iWord) ^ mask_s;
        for (int i = 0; i < 9; i++) begin
            next_s[i] = clip($signed({x_r[(i + 8) % 9][2], x_r[(i + 8) % 9]})
                             + (drive_s[i] ? 4'sd1 : -4'sd1));
        end
    end

    // Neuron registers: async clear, otherwise step only when enabled.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 9; i++) begin
                x_r[i] <= 3'sd0;
            end
        end else if (iEn) begin
            for (int i = 0; i < 9; i++) begin
                x_r[i] <= next_s[i];
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                x_r[i] <= x_r[i];
            end
        end
    end

    // Sign vector straight off the registers; zero reads as 0.
    always_comb begin
        oOut = 9'h000;
        for (int i = 0; i < 9; i++) begin
            oOut[i] = (x_r[i] > 3'sd0);
        end
    end

endmodule

// File: tb/tb_reservoir.sv
// Directed scoreboard bench for reservoir: stimulus queues expected sign vectors, a
// negedge monitor pops and compares them.
module tb_reservoir;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] word;
    logic [5:0] y;
    logic [8:0] out;

    int pass_cnt = 0;
    int total_cnt = 0;

    string      name_q [$];
    logic [8:0] val_q  [$];

    reservoir #(.KAPPA(3)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iEn    (en),
        .iWord  (word),
        .iY     (y),
        .oOut   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (val_q.size() > 0) begin
            string      n;
            logic [8:0] v;
            n = name_q.pop_front();
            v = val_q.pop_front();
            total_cnt++;
            if (out === v) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: oOut=%h expected=%h", n, out, v);
            end
        end
    end

    task automatic expect_out(input string n, input logic [8:0] v);
        name_q.push_back(n);
        val_q.push_back(v);
    endtask

    task automatic step(input logic e, input logic [2:0] w, input logic [5:0] fy,
                        input string n, input logic [8:0] v);
        en   = e;
        word = w;
        y    = fy;
        @(posedge clk);
        #1;
        expect_out(n, v);
    endtask

    // Reset asserted between edges must clear oOut before the next rising edge.
    task automatic mid_reset(input string n);
        @(posedge clk);
        #1;
        en    = 1'b1;
        word  = 3'd7;
        rst_n = 1'b0;
        #1;
        expect_out(n, 9'h000);
        @(posedge clk);
        #1;
        expect_out({n, "_held"}, 9'h000);
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        word  = 3'd7;
        y     = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", 9'h000);
        rst_n = 1'b1;

        step(1'b0, 3'd0, 6'h00, "idle1", 9'h000);
        step(1'b0, 3'd0, 6'h00, "idle2", 9'h000);
        step(1'b1, 3'd0, 6'h00, "w0_step1", 9'h1A5);
        step(1'b1, 3'd0, 6'h00, "w0_step2", 9'h101);
        step(1'b1, 3'd0, 6'h00, "w0_step3", 9'h187);
        step(1'b0, 3'd5, 6'h2A, "hold1", 9'h187);
        step(1'b0, 3'd2, 6'h15, "hold2", 9'h187);
        step(1'b0, 3'd6, 6'h3F, "hold3", 9'h187);
        mid_reset("midrun_reset");

        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 3'd7, 6'h00, $sformatf("sat_up%0d", i), 9'h1FF);
        end
        step(1'b1, 3'd7, 6'h3F, "down1", 9'h1FF);
        step(1'b1, 3'd7, 6'h3F, "down2", 9'h1FF);
        for (int i = 3; i <= 7; i++) begin
            step(1'b1, 3'd7, 6'h3F, $sformatf("down%0d", i), 9'h000);
        end
        step(1'b1, 3'd7, 6'h00, "recover1", 9'h000);
        step(1'b1, 3'd7, 6'h00, "recover2", 9'h000);
        step(1'b1, 3'd7, 6'h00, "recover3", 9'h000);
        step(1'b1, 3'd7, 6'h00, "recover4", 9'h1FF);

        mid_reset("reset2");
        step(1'b1, 3'd3, 6'h15, "mask_mix", 9'h1EC);
        step(1'b1, 3'd5, 6'h00, "w5_next", 9'h058);

        for (int t = 0; t < 10 && val_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (val_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d checks left pending, expected 0", val_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
